prince_dec_iter: RTL and testbench
==================================

# prince_dec_iter

Iterative PRINCE decryption core, one round per clock, with valid/ready handshakes on the input and output sides. It is the decrypt-direction counterpart of the PRINCE encrypt datapath and reuses the same S-box, M' and ShiftRows layers. It sits between the ciphertext source and the plaintext sink. Exactly one block is in flight at a time.

## Interface
- Parameters: none.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext and key present.
- in_ready  out  1  core can accept a new block; high only in IDLE.
- in_data  in  64  ciphertext; nibble 0 is bits [63:60].
- in_key  in  128  k0 = [127:64], k1 = [63:0].
- out_valid  out  1  plaintext available.
- out_ready  in  1  sink accepts plaintext.
- out_data  out  64  plaintext.

## Operation
- Decryption is the PRINCE encryption structure with keys transformed as follows:
  - input whitening key = k0' = (k0 >>> 1) ^ (k0 >> 63);
  - output whitening key = k0;
  - core key kc = k1 ^ ALPHA, where ALPHA = 64'hc0ac29b7c97c50dd.
- Layers:
  - S: 16-entry S-box B F 3 2 A C 9 1 6 7 8 0 E 5 D 4.
  - S^-1: B 7 3 2 F D 8 9 A 6 4 0 5 E C 1.
  - M': the existing involutive M' linear layer.
  - SR: output nibble i = input nibble P[i], with P = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
  - SR^-1: the inverse of SR.
  - M = SR(M'(x)); M^-1 = M'(SR^-1(x)).
- Round constants RC0..RC11 are the standard PRINCE values. RC0 = 0 and RC11 = ALPHA. For all i, RCi ^ RC(11-i) = ALPHA.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid && in_ready. The acceptance edge loads st = in_data ^ k0' ^ kc ^ RC0, latches k0 and kc, and sets round counter r = 1.
  - RUN, r = 1..5: st = M(S(st)) ^ RCr ^ kc.
  - RUN, r = 6 (middle): st = S^-1(M'(S(st))).
  - RUN, r = 7..11 (rounds 6..10): st = S^-1(M^-1(st ^ kc ^ RC(r-1))).
  - At r = 11 the final whitening is fused in: out_data is loaded with st_next ^ RC11 ^ kc ^ k0, and the FSM moves to DONE.
  - r increments by 1 per cycle; it is 4 bits wide and never exceeds 11.
  - DONE -> IDLE on out_valid && out_ready.
- out_data and out_valid are registered. out_data holds its value until the next block completes.
- in_data and in_key are sampled only on the acceptance edge. Changes to them while the FSM is in RUN or DONE have no effect.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, st = 0, r = 0.
- Reset asserted in any state aborts the operation at that edge. No out_valid is produced for the aborted block.
- Latency: out_valid rises exactly 11 cycles after the acceptance edge.
  - Acceptance edge E0; round edges E1..E11; out_valid is high after E11.
- in_ready is low from the edge after acceptance until the edge after the output handshake.
- Minimum issue interval is 13 cycles: 11 compute cycles, 1 DONE cycle with out_ready high, 1 IDLE cycle.
- out_valid stays high and out_data stays stable while out_ready is low, for any number of cycles.
- in_valid asserted in RUN or DONE is ignored, because in_ready is low.
- in_valid high in the same cycle that the DONE handshake completes is not accepted; it is accepted on the following cycle in IDLE.

## Test plan
- ct 818665aa0d02dfda, k0 = 0, k1 = 0 -> out_data 0000000000000000; out_valid rises 11 cycles after acceptance.
- ct 604ae6ca03c20ada, k0 = 0, k1 = 0 -> ffffffffffffffff.
- ct 9fb51935fc3df524, k0 = ffffffffffffffff, k1 = 0 -> 0000000000000000. Then ct 78a54cbe737bb7ef, k0 = 0, k1 = ffffffffffffffff -> 0000000000000000.
- ct ae25ad3ca8fa9ccf, k0 = 0, k1 = fedcba9876543210 -> 0123456789abcdef. Hold out_ready low for 7 cycles: out_valid and out_data must stay stable, in_ready must stay 0, and a second in_valid with different data must be ignored.
- Back-to-back: keep in_valid and out_ready high continuously with two vectors. Two results, in order, with exactly 13 cycles between acceptances.
- Assert rst at round 5 of a block: at the next edge in_ready = 1, out_valid = 0, out_data = 0. A following block then decrypts correctly with no residue from the aborted one.

Source files
------------

// File: rtl/prince_dec_iter.sv
// rtl/prince_dec_iter.sv - iterative PRINCE decryption core, one round per clock
// Valid/ready on both sides; one block in flight; output whitening fused into the last round.
module prince_dec_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);
    localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
    // SR source nibble for each destination nibble, nibble 0 in the top hex digit
    localparam logic [63:0] SR_P  = 64'h05af49e38d27c16b;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_st;
    logic [63:0] r_k0;
    logic [63:0] r_kc;
    logic [63:0] r_out_data;
    logic [3:0]  r_round;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_last;
    logic [63:0] w_k0;
    logic [63:0] w_k0p;
    logic [63:0] w_kc;
    logic [63:0] w_sb;
    logic [63:0] w_fwd;
    logic [63:0] w_mid;
    logic [63:0] w_xk;
    logic [63:0] w_bwd;
    logic [63:0] w_st_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hb;
            4'h1: y = 4'hf;
            4'h2: y = 4'h3;
            4'h3: y = 4'h2;
            4'h4: y = 4'ha;
            4'h5: y = 4'hc;
            4'h6: y = 4'h9;
            4'h7: y = 4'h1;
            4'h8: y = 4'h6;
            4'h9: y = 4'h7;
            4'ha: y = 4'h8;
            4'hb: y = 4'h0;
            4'hc: y = 4'he;
            4'hd: y = 4'h5;
            4'he: y = 4'hd;
            default: y = 4'h4;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hb;
            4'h1: y = 4'h7;
            4'h2: y = 4'h3;
            4'h3: y = 4'h2;
            4'h4: y = 4'hf;
            4'h5: y = 4'hd;
            4'h6: y = 4'h8;
            4'h7: y = 4'h9;
            4'h8: y = 4'ha;
            4'h9: y = 4'h6;
            4'ha: y = 4'h4;
            4'hb: y = 4'h0;
            4'hc: y = 4'h5;
            4'hd: y = 4'he;
            4'he: y = 4'hc;
            default: y = 4'h1;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox_inv(x[4*i +: 4]);
        end
        return y;
    endfunction

    // 16-bit block of M': output nibble j, bit b (MSB-first) is the XOR of all input
    // nibbles at bit b except nibble (b - j - t) mod 4; t = 0 for M0, t = 1 for M1.
    function automatic logic [15:0] m_hat(input logic [15:0] x, input logic [1:0] t);
        logic [3:0][3:0] n;
        logic [3:0]      s;
        logic [15:0]     y;
        logic [1:0]      k;
        for (int c = 0; c < 4; c++) begin
            n[c] = x[15-4*c -: 4];
        end
        s = n[0] ^ n[1] ^ n[2] ^ n[3];
        y = '0;
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
                k = 2'(b - j) - t;
                y[15-4*j-b] = s[3-b] ^ n[k][3-b];
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 2'd0), m_hat(x[47:32], 2'd1),
                m_hat(x[31:16], 2'd1), m_hat(x[15:0],  2'd0)};
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  p;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            p = SR_P[63-4*i -: 4];
            y[63-4*i -: 4] = x[63-4*p -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] shift_rows_inv(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  p;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            p = SR_P[63-4*i -: 4];
            y[63-4*p -: 4] = x[63-4*i -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] round_const(input logic [3:0] i);
        logic [63:0] c;
        case (i)
            4'd1:    c = 64'h13198a2e03707344;
            4'd2:    c = 64'ha4093822299f31d0;
            4'd3:    c = 64'h082efa98ec4e6c89;
            4'd4:    c = 64'h452821e638d01377;
            4'd5:    c = 64'hbe5466cf34e90c6c;
            4'd6:    c = 64'h7ef84f78fd955cb1;
            4'd7:    c = 64'h85840851f1ac43aa;
            4'd8:    c = 64'hc882d32f25323c54;
            4'd9:    c = 64'h64a51195e0e3610d;
            4'd10:   c = 64'hd3b5a399ca0c2399;
            4'd11:   c = ALPHA;
            default: c = 64'h0;
        endcase
        return c;
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_round == 4'd11);

    // Decryption swaps the whitening keys: k0' goes in front, k0 at the end.
    assign w_k0  = in_key[127:64];
    assign w_k0p = {w_k0[0], w_k0[63:1]} ^ {63'b0, w_k0[63]};
    assign w_kc  = in_key[63:0] ^ ALPHA;

    assign w_sb  = s_layer(r_st);
    assign w_fwd = shift_rows(m_prime(w_sb)) ^ round_const(r_round) ^ r_kc;
    assign w_mid = s_inv_layer(m_prime(w_sb));
    assign w_xk  = r_st ^ r_kc ^ round_const(r_round - 4'd1);
    assign w_bwd = s_inv_layer(m_prime(shift_rows_inv(w_xk)));

    always_comb begin
        w_st_next = w_bwd;
        if (r_round <= 4'd5) begin
            w_st_next = w_fwd;
        end else if (r_round == 4'd6) begin
            w_st_next = w_mid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_RUN;
            S_RUN:   if (r_round == 4'd11) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= '0;
            r_k0        <= '0;
            r_kc        <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_st    <= in_data ^ w_k0p ^ w_kc;
                r_k0    <= w_k0;
                r_kc    <= w_kc;
                r_round <= 4'd1;
            end else if (r_state == S_RUN) begin
                r_st    <= w_st_next;
                r_round <= w_last ? 4'd0 : r_round + 4'd1;
            end
            if (w_last) begin
                r_out_data  <= w_st_next ^ ALPHA ^ r_kc ^ r_k0;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prince_dec_iter.sv
// tb/tb_prince_dec_iter.sv - directed-vector bench for prince_dec_iter
// Known-answer vectors, latency, backpressure, back-to-back issue and abort by reset.
module tb_prince_dec_iter;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    int n_checks;
    int n_fail;

    localparam logic [63:0]  CT  [5] = '{64'h818665aa0d02dfda, 64'h604ae6ca03c20ada,
                                          64'h9fb51935fc3df524, 64'h78a54cbe737bb7ef,
                                          64'hae25ad3ca8fa9ccf};
    localparam logic [127:0] KEY [5] = '{128'h0, 128'h0,
                                          {64'hffffffffffffffff, 64'h0},
                                          {64'h0, 64'hffffffffffffffff},
                                          {64'h0, 64'hfedcba9876543210}};
    localparam logic [63:0]  PT  [5] = '{64'h0, 64'hffffffffffffffff, 64'h0, 64'h0,
                                          64'h0123456789abcdef};

    prince_dec_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ct, input logic [127:0] key);
        in_data  = ct;
        in_key   = key;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
    endtask

    task automatic test_vectors();
        int cyc;
        for (int v = 0; v < 4; v++) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_ready_before: got %b expected 1", v, in_ready);
            end
            send(CT[v], KEY[v]);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_busy: in_ready got %b expected 0", v, in_ready);
            end
            wait_out(cyc);
            n_checks++;
            if (cyc != 11) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d cycles expected 11", v, cyc);
            end
            n_checks++;
            if (out_data !== PT[v]) begin
                n_fail++;
                $display("FAIL vec%0d_data: got %h expected %h", v, out_data, PT[v]);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_handshake: out_valid %b in_ready %b expected 0 1",
                         v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit spurious;
        send(CT[4], KEY[4]);
        wait_out(cyc);
        n_checks++;
        if (cyc != 11 || out_data !== PT[4]) begin
            n_fail++;
            $display("FAIL bp_result: got %h after %0d cycles expected %h after 11",
                     out_data, cyc, PT[4]);
        end
        in_data  = CT[1];
        in_key   = KEY[1];
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== PT[4] || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out_valid %b out_data %h in_ready %b expected 1 %h 0",
                         i, out_valid, out_data, in_ready, PT[4]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        spurious  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) spurious = 1'b1;
            step();
        end
        n_checks++;
        if (spurious || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ignored_input: spurious %b in_ready %b expected 0 1",
                     spurious, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          n_acc;
        int          n_out;
        int          acc_t [4];
        logic [63:0] got [2];
        cyc   = 0;
        n_acc = 0;
        n_out = 0;
        in_data   = CT[0];
        in_key    = KEY[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_out < 2 && cyc < 80) begin
            if (in_valid && in_ready && n_acc < 4) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            step();
            cyc++;
            if (n_acc == 1) begin
                in_data = CT[4];
                in_key  = KEY[4];
            end
            if (n_acc >= 2) in_valid = 1'b0;
            if (out_valid) begin
                got[n_out] = out_data;
                n_out++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_out != 2 || n_acc != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs %0d accepts expected 2 2", n_out, n_acc);
        end else begin
            n_checks++;
            if (acc_t[1] - acc_t[0] != 13) begin
                n_fail++;
                $display("FAIL b2b_interval: got %0d expected 13", acc_t[1] - acc_t[0]);
            end
            n_checks++;
            if (got[0] !== PT[0] || got[1] !== PT[4]) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h expected %h %h", got[0], got[1], PT[0], PT[4]);
            end
        end
        step();
    endtask

    task automatic test_abort();
        int cyc;
        send(CT[4], KEY[4]);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL abort_state: in_ready %b out_valid %b out_data %h expected 1 0 0",
                     in_ready, out_valid, out_data);
        end
        send(CT[1], KEY[1]);
        wait_out(cyc);
        n_checks++;
        if (cyc != 11 || out_data !== PT[1]) begin
            n_fail++;
            $display("FAIL abort_next_block: got %h after %0d cycles expected %h after 11",
                     out_data, cyc, PT[1]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
